// File: rtl/conv_window_mac.sv
// conv_window_mac: 5x5 int8 window x latched weight MAC with channel accumulation.
// Takes one window per cycle through a 3-stage multiply / row-sum / total pipeline
// and accumulates PARAM_C windows into one signed partial sum per output pixel.
module conv_window_mac #(
    parameter int ROW_WIDTH = 40,
    parameter int ACC_WIDTH = 32,
    parameter int C_WIDTH   = 12
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [ROW_WIDTH-1:0] W_ROW_0,
    input  logic [ROW_WIDTH-1:0] W_ROW_1,
    input  logic [ROW_WIDTH-1:0] W_ROW_2,
    input  logic [ROW_WIDTH-1:0] W_ROW_3,
    input  logic [ROW_WIDTH-1:0] W_ROW_4,
    input  logic                 WEIGHTS_VALID,
    input  logic [3:0]           PARAM_R,
    input  logic [3:0]           PARAM_S,
    input  logic [C_WIDTH-1:0]   PARAM_C,
    input  logic [ROW_WIDTH-1:0] IN_ROW_0,
    input  logic [ROW_WIDTH-1:0] IN_ROW_1,
    input  logic [ROW_WIDTH-1:0] IN_ROW_2,
    input  logic [ROW_WIDTH-1:0] IN_ROW_3,
    input  logic [ROW_WIDTH-1:0] IN_ROW_4,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [ACC_WIDTH-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 BUSY
);
    localparam int PW = 16;  // 8x8 signed product
    localparam int RW = 19;  // sum of 5 products
    localparam int TW = 21;  // sum of 5 row sums
    localparam logic [C_WIDTH-1:0] C_ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ROW_WIDTH-1:0] w_in_s [5];
    logic [ROW_WIDTH-1:0] x_in_s [5];
    logic [ROW_WIDTH-1:0] w_q    [5];
    logic [4:0]           row_en_q, col_en_q;
    logic [C_WIDTH-1:0]   c_q, cnt_q, cnt_d;
    logic                 load_s, hs_s;
    logic                 v1_q, v2_q, v3_q;
    logic signed [PW-1:0] prod_d [5][5];
    logic signed [PW-1:0] prod_q [5][5];
    logic signed [RW-1:0] rsum_d [5];
    logic signed [RW-1:0] rsum_q [5];
    logic signed [TW-1:0] tot_d, tot_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q;
    logic                 in_ready_d, in_ready_q;
    logic                 out_valid_d, out_valid_q;
    logic                 busy_d, busy_q;
    logic [ACC_WIDTH-1:0] out_data_d, out_data_q;

    // Enable mask for the first lim rows/columns; limits above 5 saturate to all five.
    function automatic logic [4:0] dim_mask(input logic [3:0] lim);
        logic [4:0] m;
        for (int i = 0; i < 5; i++) begin
            m[i] = (4'(i) < lim);
        end
        return m;
    endfunction

    // Gather row ports into arrays for loop-based datapath code.
    always_comb begin
        w_in_s[0] = W_ROW_0;  w_in_s[1] = W_ROW_1;  w_in_s[2] = W_ROW_2;
        w_in_s[3] = W_ROW_3;  w_in_s[4] = W_ROW_4;
        x_in_s[0] = IN_ROW_0; x_in_s[1] = IN_ROW_1; x_in_s[2] = IN_ROW_2;
        x_in_s[3] = IN_ROW_3; x_in_s[4] = IN_ROW_4;
    end

    // Control: next state, channel counter, weight load strobe and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        hs_s    = IN_VALID & in_ready_q;
        case (state_q)
            IDLE: begin
                if (WEIGHTS_VALID) begin
                    state_d = RUN;
                    load_s  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (hs_s) begin
                    cnt_d = cnt_q + C_ONE;
                    if (cnt_d == c_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!(v1_q | v2_q | v3_q)) begin
                    state_d = OUT;
                end else begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (OUT_READY && out_valid_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
        // RUN is left on the last accepted window, so readiness is simply "in RUN".
        in_ready_d  = (state_d == RUN);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
        if ((state_d == OUT) && (state_q != OUT)) begin
            out_data_d = acc_q;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Stage 1 products: column s sits in byte [39-8s:32-8s]; masked taps contribute 0.
    always_comb begin
        logic [7:0] xb;
        logic [7:0] wb;
        xb = 8'd0;
        wb = 8'd0;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < 5; s++) begin
                xb = x_in_s[r][ROW_WIDTH-1-8*s -: 8];
                wb = w_q[r][ROW_WIDTH-1-8*s -: 8];
                if (row_en_q[r] && col_en_q[s]) begin
                    prod_d[r][s] = {{8{xb[7]}}, xb} * {{8{wb[7]}}, wb};
                end else begin
                    prod_d[r][s] = '0;
                end
            end
        end
    end

    // Stages 2 and 3 sums, sign-extended, plus accumulator update (wraps mod 2^ACC_WIDTH).
    always_comb begin
        tot_d = '0;
        for (int r = 0; r < 5; r++) begin
            rsum_d[r] = '0;
            for (int s = 0; s < 5; s++) begin
                rsum_d[r] = rsum_d[r] + {{(RW-PW){prod_q[r][s][PW-1]}}, prod_q[r][s]};
            end
            tot_d = tot_d + {{(TW-RW){rsum_q[r][RW-1]}}, rsum_q[r]};
        end
        if (load_s) begin
            acc_d = '0;
        end else if (v3_q) begin
            acc_d = acc_q + {{(ACC_WIDTH-TW){tot_q[TW-1]}}, tot_q};
        end else begin
            acc_d = acc_q;
        end
    end

    // Control registers and latched per-pixel weights/parameters.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            c_q         <= '0;
            row_en_q    <= 5'd0;
            col_en_q    <= 5'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            for (int r = 0; r < 5; r++) w_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
            if (load_s) begin
                row_en_q <= dim_mask(PARAM_R);
                col_en_q <= dim_mask(PARAM_S);
                c_q      <= (PARAM_C == '0) ? C_ONE : PARAM_C;
                for (int r = 0; r < 5; r++) w_q[r] <= w_in_s[r];
            end else begin
                row_en_q <= row_en_q;
                col_en_q <= col_en_q;
                c_q      <= c_q;
            end
        end
    end

    // Pipeline data and valid registers; bubbles advance as invalid slots.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            tot_q <= '0;
            for (int r = 0; r < 5; r++) begin
                rsum_q[r] <= '0;
                for (int s = 0; s < 5; s++) prod_q[r][s] <= '0;
            end
        end else begin
            v1_q  <= hs_s;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            tot_q <= tot_d;
            for (int r = 0; r < 5; r++) begin
                rsum_q[r] <= rsum_d[r];
                for (int s = 0; s < 5; s++) prod_q[r][s] <= prod_d[r][s];
            end
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign BUSY      = busy_q;

endmodule
